// File: rtl/vector_cum_core.sv
// Sequential signed accumulator over a vector of streamed elements, wrapped in
// an ap_start/ap_ready/ap_done/ap_idle handshake with a four-state controller.
module vector_cum_core #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ap_start,
    output logic                     ap_ready,
    output logic                     ap_done,
    output logic                     ap_idle,
    input  logic [LEN_W-1:0]         vec_len,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [ACC_W-1:0]  ap_return
);

    localparam int EXT_W = (ACC_W > DATA_W) ? ACC_W : DATA_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_ACK   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Sign-extend to the wider of the two widths first, so a narrow accumulator
    // still sees the element's low bits; the sum wraps modulo 2^ACC_W.
    function automatic logic signed [ACC_W-1:0] add_wrap(
        input logic signed [ACC_W-1:0]  a,
        input logic signed [DATA_W-1:0] d
    );
        logic signed [EXT_W-1:0] d_ext;
        d_ext = EXT_W'(d);
        return a + signed'(d_ext[ACC_W-1:0]);
    endfunction

    logic [1:0]              state;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        count;
    logic signed [ACC_W-1:0] acc;
    logic                    xfer;
    logic                    last;

    assign ap_idle  = (state == S_IDLE);
    assign in_ready = (state == S_ACCUM);
    assign ap_ready = (state == S_ACK);
    assign ap_done  = (state == S_DONE);

    assign xfer = in_valid && in_ready;
    assign last = (count == len_q - LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            acc       <= '0;
            count     <= '0;
            len_q     <= '0;
            ap_return <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        len_q <= vec_len;
                        acc   <= '0;
                        count <= '0;
                        state <= (vec_len == '0) ? S_ACK : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (xfer) begin
                        acc   <= add_wrap(acc, in_data);
                        count <= count + LEN_W'(1);
                        if (last) begin
                            state <= S_ACK;
                        end
                    end
                end
                // Result is captured on the way into DONE so it is valid alongside ap_done.
                S_ACK: begin
                    ap_return <= acc;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
